// File: rtl/idu.sv
// ---------------------------------------------------------------------------
// idu -- instruction decode unit
//
// Decodes OP-IMM, LUI, AUIPC and EBREAK from the fetch stage and presents a
// one-entry registered decode slot to the execute stage. EBREAK halts the
// unit and any other encoding traps it into an error state. Both states
// persist until reset.
//
// Ports
//   clk        clock, rising-edge
//   rst        asynchronous reset, active low
//   if_valid   fetch offers if_inst / if_pc
//   if_ready   decode accepts this cycle
//   if_inst    instruction word
//   if_pc      PC of if_inst
//   rf_raddr1  register-file read address (rs1), combinational
//   rf_rdata1  register-file read data, same cycle
//   flush      drop the held decoded instruction
//   ex_valid   decoded instruction held for execute
//   ex_ready   execute consumes the held instruction
//   ex_opcode  inst[6:0]
//   ex_funct3  inst[14:12]
//   ex_rd      inst[11:7]
//   ex_src1    first operand
//   ex_imm     sign-extended immediate
//   ex_pc      PC of the held instruction
//   halt       EBREAK decoded (sticky until reset)
//   illegal    unsupported encoding decoded (sticky until reset)
// ---------------------------------------------------------------------------
module idu #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_raddr1,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_src1,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic            halt,
  output logic            illegal
);

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [31:0] INST_EBRK  = 32'h0010_0073;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    ERR
  } state_t;

  state_t state;

  logic            accept;
  logic            dec_legal;
  logic            dec_ebreak;
  logic [XLEN-1:0] dec_src1;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;

  assign rf_raddr1 = if_inst[19:15];

  // Reset is folded in so the handshake is quiet while rst is held low.
  assign if_ready = rst & (state == RUN) & (~ex_valid | ex_ready) & ~flush;
  assign accept   = if_valid & if_ready;

  assign halt     = (state == HALT);
  assign illegal  = (state == ERR);

  assign imm_i = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
  assign imm_u = {{(XLEN-32){if_inst[31]}}, if_inst[31:12], 12'b0};

  always_comb begin
    dec_legal  = 1'b0;
    dec_ebreak = (if_inst == INST_EBRK);
    dec_src1   = '0;
    dec_imm    = '0;
    case (if_inst[6:0])
      OPC_OP_IMM: begin
        dec_src1 = (if_inst[19:15] == 5'd0) ? '0 : rf_rdata1;
        dec_imm  = imm_i;
        case (if_inst[14:12])
          3'b001:  dec_legal = (if_inst[31:26] == 6'b000000);
          3'b101:  dec_legal = (if_inst[31:26] == 6'b000000) ||
                               (if_inst[31:26] == 6'b010000);
          default: dec_legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_imm   = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_src1  = if_pc;
        dec_imm   = imm_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_funct3 <= '0;
      ex_rd     <= '0;
      ex_src1   <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
    end else begin
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (accept) begin
        // An accept implies the slot is empty or being consumed this cycle,
        // so a non-loading accept (EBREAK/illegal) leaves the slot empty.
        if (dec_ebreak) begin
          state    <= HALT;
          ex_valid <= 1'b0;
        end else if (!dec_legal) begin
          state    <= ERR;
          ex_valid <= 1'b0;
        end else begin
          ex_valid  <= 1'b1;
          ex_opcode <= if_inst[6:0];
          ex_funct3 <= if_inst[14:12];
          ex_rd     <= if_inst[11:7];
          ex_src1   <= dec_src1;
          ex_imm    <= dec_imm;
          ex_pc     <= if_pc;
        end
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_idu.sv
module tb_idu;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic [4:0]  rf_raddr1;
  logic [63:0] rf_rdata1;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [63:0] ex_src1;
  logic [63:0] ex_imm;
  logic [63:0] ex_pc;
  logic        halt;
  logic        illegal;

  idu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .ex_src1(ex_src1), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .halt(halt), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and check outputs clear before any edge.
  task automatic do_reset();
    rst = 1'b0; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    if_inst = '0; if_pc = '0; rf_rdata1 = '0;
    #3;
    chk("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_halt", {63'd0, halt}, 64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    chk("rst_if_ready", {63'd0, if_ready}, 64'd0);
    chk("rst_ex_imm", ex_imm, 64'd0);
    chk("rst_ex_src1", ex_src1, 64'd0);
    step();
    rst = 1'b1;
    #1;
  endtask

  localparam logic [1:0] K_OK = 2'd0, K_HALT = 2'd1, K_ILL = 2'd2;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] rdata;
    logic [1:0]  kind;
    logic [4:0]  rs1;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [63:0] src1;
    logic [63:0] imm;
  } vec_t;

  vec_t vt[12];

  logic [6:0]  s_op;
  logic [4:0]  s_rd;
  logic [63:0] s_src1, s_imm, s_pc;

  initial begin
    //        inst          pc                     rdata                  kind    rs1 op        f3  rd  src1                   imm
    vt[0]  = '{32'hFFF10093, 64'h1000,             64'd5,                 K_OK,   2,  7'h13,    0,  1,  64'd5,                 64'hFFFF_FFFF_FFFF_FFFF};
    vt[1]  = '{32'h800002B7, 64'h1004,             64'h1234,              K_OK,   0,  7'h37,    0,  5,  64'd0,                 64'hFFFF_FFFF_8000_0000};
    vt[2]  = '{32'h00001517, 64'h8000_0000,        64'h55,                K_OK,   0,  7'h17,    1,  10, 64'h8000_0000,         64'h1000};
    vt[3]  = '{32'h00500193, 64'h100C,             64'hDEAD,              K_OK,   0,  7'h13,    0,  3,  64'd0,                 64'd5};
    vt[4]  = '{32'h00331213, 64'h1010,             64'h77,                K_OK,   6,  7'h13,    1,  4,  64'h77,                64'd3};
    vt[5]  = '{32'h40445393, 64'h1014,             64'hA5A5_0000_1111,    K_OK,   8,  7'h13,    5,  7,  64'hA5A5_0000_1111,    64'h404};
    vt[6]  = '{32'h80057493, 64'h1018,             64'hFFFF_0000_FFFF_0000, K_OK, 10, 7'h13,    7,  9,  64'hFFFF_0000_FFFF_0000, 64'hFFFF_FFFF_FFFF_F800};
    vt[7]  = '{32'h04331213, 64'h101C,             64'h1,                 K_ILL,  6,  7'h13,    1,  4,  64'd0,                 64'd0};
    vt[8]  = '{32'h80445393, 64'h1020,             64'h1,                 K_ILL,  8,  7'h13,    5,  7,  64'd0,                 64'd0};
    vt[9]  = '{32'h00100073, 64'h1024,             64'h0,                 K_HALT, 0,  7'h73,    0,  0,  64'd0,                 64'd0};
    vt[10] = '{32'h00000000, 64'h1028,             64'h0,                 K_ILL,  0,  7'h00,    0,  0,  64'd0,                 64'd0};
    vt[11] = '{32'h00000073, 64'h102C,             64'h0,                 K_ILL,  0,  7'h73,    0,  0,  64'd0,                 64'd0};

    rst = 1'b0; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    if_inst = '0; if_pc = '0; rf_rdata1 = '0;
    #1;

    // ---------------- table-driven single-instruction vectors -----------
    for (int i = 0; i < 12; i++) begin
      do_reset();
      if_valid = 1'b1; ex_ready = 1'b1;
      if_inst = vt[i].inst; if_pc = vt[i].pc; rf_rdata1 = vt[i].rdata;
      #1;
      chk($sformatf("v%0d_raddr", i), {59'd0, rf_raddr1}, {59'd0, vt[i].rs1});
      chk($sformatf("v%0d_if_ready", i), {63'd0, if_ready}, 64'd1);
      step();
      if (vt[i].kind == K_OK) begin
        if_valid = 1'b0;
        chk($sformatf("v%0d_ex_valid", i), {63'd0, ex_valid}, 64'd1);
        chk($sformatf("v%0d_opcode", i), {57'd0, ex_opcode}, {57'd0, vt[i].op});
        chk($sformatf("v%0d_funct3", i), {61'd0, ex_funct3}, {61'd0, vt[i].f3});
        chk($sformatf("v%0d_rd", i), {59'd0, ex_rd}, {59'd0, vt[i].rd});
        chk($sformatf("v%0d_src1", i), ex_src1, vt[i].src1);
        chk($sformatf("v%0d_imm", i), ex_imm, vt[i].imm);
        chk($sformatf("v%0d_pc", i), ex_pc, vt[i].pc);
        chk($sformatf("v%0d_halt", i), {63'd0, halt}, 64'd0);
        chk($sformatf("v%0d_illegal", i), {63'd0, illegal}, 64'd0);
        step();
        chk($sformatf("v%0d_drain", i), {63'd0, ex_valid}, 64'd0);
      end else begin
        chk($sformatf("v%0d_ex_valid", i), {63'd0, ex_valid}, 64'd0);
        chk($sformatf("v%0d_halt", i), {63'd0, halt}, {63'd0, vt[i].kind == K_HALT});
        chk($sformatf("v%0d_illegal", i), {63'd0, illegal}, {63'd0, vt[i].kind == K_ILL});
        chk($sformatf("v%0d_blocked", i), {63'd0, if_ready}, 64'd0);
        // A legal instruction offered afterwards must still be refused.
        if_inst = 32'h00500193;
        step();
        chk($sformatf("v%0d_stuck_valid", i), {63'd0, ex_valid}, 64'd0);
        chk($sformatf("v%0d_stuck_ready", i), {63'd0, if_ready}, 64'd0);
        chk($sformatf("v%0d_sticky", i), {62'd0, halt, illegal},
            (vt[i].kind == K_HALT) ? 64'd2 : 64'd1);
      end
    end

    // ---------------- backpressure then refill with no bubble ------------
    do_reset();
    if_valid = 1'b1; ex_ready = 1'b0;
    if_inst = 32'hFFF10093; if_pc = 64'h2000; rf_rdata1 = 64'd5;
    step();
    chk("bp_load_valid", {63'd0, ex_valid}, 64'd1);
    s_op = ex_opcode; s_rd = ex_rd; s_src1 = ex_src1; s_imm = ex_imm; s_pc = ex_pc;
    chk("bp_load_imm", s_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    if_inst = 32'h800002B7; if_pc = 64'h2004; rf_rdata1 = 64'h99;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_if_ready", c), {63'd0, if_ready}, 64'd0);
      step();
      chk($sformatf("bp%0d_valid", c), {63'd0, ex_valid}, 64'd1);
      chk($sformatf("bp%0d_op", c), {57'd0, ex_opcode}, 64'h13);
      chk($sformatf("bp%0d_rd", c), {59'd0, ex_rd}, 64'd1);
      chk($sformatf("bp%0d_src1", c), ex_src1, 64'd5);
      chk($sformatf("bp%0d_imm", c), ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk($sformatf("bp%0d_pc", c), ex_pc, 64'h2000);
    end
    ex_ready = 1'b1;
    #1;
    chk("refill_if_ready", {63'd0, if_ready}, 64'd1);
    step();
    if_valid = 1'b0; ex_ready = 1'b0;
    chk("refill_valid", {63'd0, ex_valid}, 64'd1);
    chk("refill_op", {57'd0, ex_opcode}, 64'h37);
    chk("refill_rd", {59'd0, ex_rd}, 64'd5);
    chk("refill_imm", ex_imm, 64'hFFFF_FFFF_8000_0000);
    chk("refill_pc", ex_pc, 64'h2004);

    // ---------------- flush beats accept and hold -------------------------
    if_valid = 1'b1; flush = 1'b1;
    if_inst = 32'h00500193; if_pc = 64'h3000;
    #1;
    chk("flush_if_ready", {63'd0, if_ready}, 64'd0);
    step();
    flush = 1'b0; if_valid = 1'b0;
    chk("flush_valid", {63'd0, ex_valid}, 64'd0);
    chk("flush_not_accepted_pc", ex_pc, 64'h2004);
    chk("flush_state_kept", {62'd0, halt, illegal}, 64'd0);
    #1;
    chk("flush_ready_after", {63'd0, if_ready}, 64'd1);

    // ---------------- async reset mid-stream ------------------------------
    if_valid = 1'b1; ex_ready = 1'b0;
    if_inst = 32'h00001517; if_pc = 64'h8000_0000;
    step();
    chk("mid_valid", {63'd0, ex_valid}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {63'd0, ex_valid}, 64'd0);
    chk("arst_src1", ex_src1, 64'd0);
    chk("arst_imm", ex_imm, 64'd0);
    chk("arst_pc", ex_pc, 64'd0);
    chk("arst_op", {57'd0, ex_opcode}, 64'd0);
    chk("arst_if_ready", {63'd0, if_ready}, 64'd0);
    step();
    rst = 1'b1;
    #1;
    chk("post_rst_ready", {63'd0, if_ready}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
